// File: rtl/rx_line_editor_pkg.sv
// Shared ASCII constants and FSM state type for the receive line editor.
package rx_line_editor_pkg;

    localparam logic [7:0] ASCII_BEL   = 8'h07;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } state_t;

endpackage

// File: rtl/rx_line_editor_echo_fifo.sv
// Echo byte FIFO: head is presented combinationally, reads as zero when empty.
module echo_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign free_cnt = CW'(DEPTH) - count;
    assign pop_data = empty ? 8'h00 : mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage array; contents are don't-care until pointed at by a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_line_editor.sv
// Line editor between uart_rx and the digit display; echoes edits to uart_tx.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for r_valid; decodes and applies the edit on arrival
// ST_PUSH | writing the reserved echo sequence into the FIFO, one per cycle
module rx_line_editor
    import rx_line_editor_pkg::*;
#(
    parameter int         N_DIGITS   = 8,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] BLANK      = 8'h20
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [7:0]                r_data,
    input  logic                      r_valid,
    output logic [N_DIGITS-1:0][7:0]  digits,
    output logic                      line_done,
    output logic                      overflow,
    output logic                      rx_drop,
    output logic                      echo_drop,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
);

    localparam int LW = $clog2(N_DIGITS + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                 state;
    logic [N_DIGITS-1:0][7:0] ebuf;
    logic [LW-1:0]          len;
    logic [2:0][7:0]        seq;
    logic [1:0]             seq_len;
    logic [1:0]             seq_idx;

    logic [2:0][7:0]        dec_seq;
    logic [1:0]             dec_len;
    logic                   is_print;
    logic                   is_bs;
    logic                   is_cr;
    logic                   is_esc;
    logic                   buf_full;
    logic                   echo_ok;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_free;
    logic [IW-1:0]          len_idx;

    assign is_print = (r_data >= ASCII_SPACE) && (r_data <= ASCII_TILDE);
    assign is_bs    = (r_data == ASCII_BS) || (r_data == ASCII_DEL);
    assign is_cr    = (r_data == ASCII_CR);
    assign is_esc   = (r_data == ASCII_ESC);
    assign buf_full = (len >= LW'(N_DIGITS));
    assign len_idx  = IW'(len);

    // Echo sequence implied by the incoming byte and current buffer length.
    always_comb begin
        dec_seq = '0;
        dec_len = 2'd0;
        if (is_print) begin
            dec_len    = 2'd1;
            dec_seq[0] = buf_full ? ASCII_BEL : r_data;
        end else if (is_bs && (len != '0)) begin
            dec_len    = 2'd3;
            dec_seq[0] = ASCII_BS;
            dec_seq[1] = ASCII_SPACE;
            dec_seq[2] = ASCII_BS;
        end else if (is_cr) begin
            dec_len    = 2'd2;
            dec_seq[0] = ASCII_CR;
            dec_seq[1] = ASCII_LF;
        end
    end

    // Whole sequence must fit now; free space only grows while we wait in IDLE.
    assign echo_ok = !fifo_full && (fifo_free >= CW'(dec_len));

    // Edit/commit FSM with registered display and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            ebuf      <= {N_DIGITS{BLANK}};
            len       <= '0;
            digits    <= {N_DIGITS{BLANK}};
            overflow  <= 1'b0;
            line_done <= 1'b0;
            rx_drop   <= 1'b0;
            echo_drop <= 1'b0;
            seq       <= '0;
            seq_len   <= 2'd0;
            seq_idx   <= 2'd0;
        end else begin
            line_done <= 1'b0;
            rx_drop   <= 1'b0;
            echo_drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (r_valid) begin
                        if (is_print) begin
                            if (!buf_full) begin
                                ebuf[len_idx] <= r_data;
                                len           <= len + LW'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (is_bs) begin
                            if (len != '0) len <= len - LW'(1);
                        end else if (is_cr) begin
                            for (int i = 0; i < N_DIGITS; i++) begin
                                digits[i] <= (LW'(i) < len) ? ebuf[i] : BLANK;
                            end
                            len       <= '0;
                            overflow  <= 1'b0;
                            line_done <= 1'b1;
                        end else if (is_esc) begin
                            len      <= '0;
                            overflow <= 1'b0;
                        end
                        if (dec_len != 2'd0) begin
                            if (echo_ok) begin
                                state   <= ST_PUSH;
                                seq     <= dec_seq;
                                seq_len <= dec_len;
                                seq_idx <= 2'd0;
                            end else begin
                                echo_drop <= 1'b1;
                            end
                        end
                    end
                end
                ST_PUSH: begin
                    if (r_valid) rx_drop <= 1'b1;
                    if (seq_idx == seq_len - 2'd1) state <= ST_IDLE;
                    else                           seq_idx <= seq_idx + 2'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_echo_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (state == ST_PUSH),
        .push_data (seq[seq_idx]),
        .pop       (tx_ready),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .free_cnt  (fifo_free)
    );

    assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_rx_line_editor.sv
// Scoreboard bench for rx_line_editor: expected echo bytes and committed lines
// are queued by the stimulus and checked by independent monitors.
module tb_rx_line_editor;

    localparam int N = 8;

    logic             clk;
    logic             rstn;
    logic [7:0]       r_data;
    logic             r_valid;
    logic [N-1:0][7:0] digits;
    logic             line_done;
    logic             overflow;
    logic             rx_drop;
    logic             echo_drop;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0]        exp_tx[$];
    logic [N*8-1:0]    exp_line[$];

    logic last_rx_drop;
    logic last_echo_drop;

    rx_line_editor #(.N_DIGITS(N), .FIFO_DEPTH(4), .BLANK(8'h20)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .r_data    (r_data),
        .r_valid   (r_valid),
        .digits    (digits),
        .line_done (line_done),
        .overflow  (overflow),
        .rx_drop   (rx_drop),
        .echo_drop (echo_drop),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*8-1:0] mk_line(input string s);
        logic [N-1:0][7:0] v;
        for (int i = 0; i < N; i++) v[i] = (i < s.len()) ? s[i] : 8'h20;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Echo monitor: each accepted byte must be the next expected one.
    always @(negedge clk) begin
        if (rstn && tx_valid && tx_ready) begin
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_tx.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_byte: got %h expected %h", tx_data, e);
                end
            end
        end
    end

    // Line monitor: each line_done pulse must carry the next expected line.
    always @(negedge clk) begin
        if (rstn && line_done) begin
            checks++;
            if (exp_line.size() == 0) begin
                errors++;
                $display("FAIL line_unexpected: got %h expected none", digits);
            end else begin
                logic [N*8-1:0] e;
                e = exp_line.pop_front();
                if (digits !== e) begin
                    errors++;
                    $display("FAIL line_digits: got %h expected %h", digits, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one byte for one cycle; capture the pulses the edit produced.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        r_data  = b;
        r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        last_rx_drop   = rx_drop;
        last_echo_drop = echo_drop;
    endtask

    task automatic send_str(input string s, input logic echo);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (echo) exp_tx.push_back(s[i]);
            wait_cyc(4);
        end
    endtask

    task automatic send_cr();
        send(8'h0D);
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
        wait_cyc(5);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 tx_ready = v;
    endtask

    initial begin
        rstn     = 1'b0;
        r_data   = 8'h00;
        r_valid  = 1'b0;
        tx_ready = 1'b1;
        last_rx_drop   = 1'b0;
        last_echo_drop = 1'b0;
        wait_cyc(3);
        check("rst_digits", 64'(digits), 64'(mk_line("")));
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_flags", 64'({overflow, line_done, rx_drop, echo_drop}), 64'd0);
        rstn = 1'b1;
        wait_cyc(2);

        // "123" CR
        exp_line.push_back(mk_line("123"));
        send_str("123", 1'b1);
        send_cr();

        // Overflow on the ninth printable byte
        exp_line.push_back(mk_line("ABCDEFGH"));
        send_str("ABCDEFGH", 1'b1);
        check("ovf_before", 64'(overflow), 64'd0);
        send(8'h49);
        exp_tx.push_back(8'h07);
        wait_cyc(4);
        check("ovf_set", 64'(overflow), 64'd1);
        send_cr();
        check("ovf_clr", 64'(overflow), 64'd0);

        // Backspace editing
        exp_line.push_back(mk_line("AC"));
        send_str("AB", 1'b1);
        send(8'h08);
        exp_tx.push_back(8'h08);
        exp_tx.push_back(8'h20);
        exp_tx.push_back(8'h08);
        wait_cyc(5);
        send_str("C", 1'b1);
        send_cr();
        send(8'h7F);
        check("bs_empty_nodrop", 64'(last_echo_drop), 64'd0);
        wait_cyc(4);
        check("bs_empty_noecho", 64'(tx_valid), 64'd0);

        // ESC discards, LF ignored, empty CR commits a blank line
        exp_line.push_back(mk_line(""));
        send_str("XY", 1'b1);
        send(8'h1B);
        send(8'h0A);
        wait_cyc(2);
        send_cr();

        // FIFO full: backspace applies but its echo is dropped
        set_ready(1'b0);
        send_str("ABCD", 1'b1);
        check("full_tx_valid", 64'(tx_valid), 64'd1);
        send(8'h08);
        check("echo_drop", 64'(last_echo_drop), 64'd1);
        set_ready(1'b1);
        wait_cyc(8);
        exp_line.push_back(mk_line("ABC"));
        send_cr();

        // Byte arriving during PUSH is dropped
        exp_line.push_back(mk_line(""));
        send_str("Q", 1'b1);
        send(8'h08);
        exp_tx.push_back(8'h08);
        exp_tx.push_back(8'h20);
        exp_tx.push_back(8'h08);
        send(8'h5A);
        check("rx_drop", 64'(last_rx_drop), 64'd1);
        wait_cyc(5);
        send_cr();

        // Reset in the middle of a push sequence
        set_ready(1'b0);
        send_str("M", 1'b0);
        send(8'h08);
        rstn = 1'b0;
        #1;
        check("midrst_tx_valid", 64'(tx_valid), 64'd0);
        check("midrst_tx_data", 64'(tx_data), 64'd0);
        check("midrst_digits", 64'(digits), 64'(mk_line("")));
        wait_cyc(2);
        rstn = 1'b1;
        set_ready(1'b1);
        wait_cyc(4);
        check("postrst_empty", 64'(tx_valid), 64'd0);
        exp_line.push_back(mk_line("OK"));
        send_str("OK", 1'b1);
        send_cr();

        wait_cyc(10);
        check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
        check("line_queue_drained", 64'(exp_line.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_line_editor.md
RX_LINE_EDITOR -- requirements
Module: rx_line_editor

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of display characters and edit-buffer depth.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=4): echo FIFO entries.
REQ-003 SHALL have parameter BLANK, default 8'h20: fill character for unused display positions.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 r_data  input  8  received byte from UART receiver.
REQ-007 r_valid  input  1  one-cycle strobe: r_data valid.
REQ-008 digits  output  N_DIGITS x 8  committed characters for display; digits[0] is leftmost.
REQ-009 line_done  output  1  one-cycle pulse when a line is committed.
REQ-010 overflow  output  1  sticky: a printable byte was dropped on a full edit buffer.
REQ-011 rx_drop  output  1  one-cycle pulse: r_valid arrived while the FSM was not IDLE; byte discarded.
REQ-012 echo_drop  output  1  one-cycle pulse: echo sequence discarded for lack of FIFO space.
REQ-013 tx_data, tx_valid  output  8, 1  echo stream to UART transmitter; tx_data is the FIFO head.
REQ-014 tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready.

Function
REQ-015 SHALL keep an edit buffer ebuf[N_DIGITS] and length len (0..N_DIGITS).
REQ-016 SHALL run the FSM IDLE/PUSH: IDLE + r_valid decodes the byte, applies the edit at that edge, and loads an echo sequence of 0-3 bytes. The FSM enters PUSH if the sequence is non-empty and FIFO free space >= sequence length. Otherwise the echo is dropped and echo_drop pulses.
REQ-017 PUSH SHALL write one sequence byte per cycle into the FIFO and return to IDLE after the last byte; space is reserved at decode, so pushes never fail.
REQ-018 Printable byte (0x20-0x7E) with len<N_DIGITS: ebuf[len]<=byte, len++, echo the byte.
REQ-019 Printable byte with len==N_DIGITS: buffer unchanged, overflow<=1, echo 0x07.
REQ-020 Backspace 0x08 or 0x7F with len>0: len--, echo 0x08,0x20,0x08. With len==0: no change, no echo.
REQ-021 CR 0x0D: digits<=ebuf[0..len-1] left-justified with positions len..N_DIGITS-1 set to BLANK, len<=0, overflow<=0, echo 0x0D,0x0A.
REQ-022 On CR, digits and line_done SHALL be updated on the same edge as the edit, i.e. visible the cycle after r_valid.
REQ-023 ESC 0x1B: len<=0, overflow<=0, digits unchanged, no echo; LF 0x0A and all other control bytes are ignored.
REQ-024 CR with len==0 SHALL commit an all-BLANK line and pulse line_done.
REQ-025 FIFO: tx_valid = not empty; pop on tx_valid&&tx_ready. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH, and the count is $clog2(FIFO_DEPTH)+1 bits.
REQ-026 r_valid in PUSH SHALL be ignored except for pulsing rx_drop.

Reset
REQ-027 rstn low SHALL immediately set: digits all BLANK, len=0, overflow=0, line_done=0, rx_drop=0, echo_drop=0, FIFO empty, tx_valid=0, tx_data=0, FSM=IDLE.
REQ-028 Reset during PUSH SHALL discard the remaining sequence; no partial FIFO content survives.

Structure
REQ-029 A shared package SHALL hold the ASCII constants (CR, LF, BS, DEL, ESC, BEL, SPACE) and the FSM state enum typedef.
REQ-030 The echo FIFO SHALL be a separate sub-module echo_fifo (push/pop/data/full/empty/free-count), parameterised by FIFO_DEPTH.
REQ-031 rx_line_editor sits between uart_rx (r_data/r_valid) and the multiplexed 8-digit display (digits), with its echo port feeding uart_tx.

Verification
REQ-032 Reset, then bytes "1","2","3",0x0D with tx_ready=1 -> digits="123     ", one line_done pulse; tx stream 0x31,0x32,0x33,0x0D,0x0A.
REQ-033 Nine printable bytes "ABCDEFGHI" then CR -> digits="ABCDEFGH", overflow=1 after "I", 0x07 echoed, overflow=0 after CR.
REQ-034 "AB",0x08,"C",0x0D -> digits="AC      ", echo includes 0x08,0x20,0x08. Backspace at len 0 -> no echo, no state change.
REQ-035 tx_ready=0, send "A","B","C","D" then 0x08 -> FIFO full, backspace applied but echo_drop pulses. Release tx_ready -> exactly "ABCD" transmitted.
REQ-036 r_valid two cycles after a backspace (FSM in PUSH) -> rx_drop pulse, ebuf unchanged.
REQ-037 Assert rstn low mid-PUSH -> FIFO empty, tx_valid=0, digits all 0x20 while low; normal operation on release.
